// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential binary-to-BCD converter (shift-add-3 / double-dabble).
// Converts one input bit per clock, BIN_W cycles per conversion, with a
// start/busy/done handshake. bcd_out feeds per-digit 7-segment decoders and is
// only updated on the done edge, so the display never shows partial results.
//
// Optional feature macro: LEADING_ZERO_BLANK_EN
//   defined   -> digits above the most significant non-zero digit read 4'hF
//                (blanked by the decoder's default); digit 0 is never blanked.
//   undefined -> raw BCD with leading zeros.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; bcd_out holds the last result
// SHIFT  | add-3 correction then shift, one bit per clock
// DONE   | single cycle with done=1 right after bcd_out updated

module bin_to_bcd_seq #(
  parameter int BIN_W  = 10,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  function automatic longint pow10(input int n);
    longint p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  localparam longint MAX_BIN = (longint'(1) << BIN_W) - 1;
  localparam longint MAX_BCD = pow10(DIGITS);

  // DIGITS must be large enough to hold the largest binary input.
  if (MAX_BCD <= MAX_BIN) begin : g_size_check
    $error("bin_to_bcd_seq: DIGITS=%0d too small for BIN_W=%0d", DIGITS, BIN_W);
  end

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [BCD_W-1:0] RST_BCD = {{(BCD_W-4){1'b1}}, 4'h0};
`else
  localparam logic [BCD_W-1:0] RST_BCD = '0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;

  logic [BIN_W-1:0]   shift_reg;
  logic [BCD_W-1:0]   scratch;
  logic [CNT_W-1:0]   cnt;

  logic [BCD_W-1:0]   scratch_adj;
  logic [BCD_W-1:0]   scratch_shf;
  logic [BIN_W-1:0]   shift_shf;
  logic [BCD_W-1:0]   final_bcd;

  logic               capture;
  logic               last_shift;
  logic               busy_nxt;
  logic               done_nxt;

  // Replace every digit above the most significant non-zero digit with 4'hF.
  function automatic logic [BCD_W-1:0] blank_lead(input logic [BCD_W-1:0] v);
    logic             seen;
    logic [BCD_W-1:0] r;
    seen = 1'b0;
    r    = v;
    for (int i = DIGITS - 1; i > 0; i--) begin
      if (v[4*i +: 4] != 4'd0) seen = 1'b1;
      if (!seen) r[4*i +: 4] = 4'hF;
    end
    return r;
  endfunction

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_SHIFT;
      S_SHIFT: if (cnt == CNT_W'(1)) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output/control decode; busy and done are registered from the next state,
  // which keeps them mutually exclusive by construction.
  always_comb begin
    capture    = (state == S_IDLE) && start;
    last_shift = (state == S_SHIFT) && (cnt == CNT_W'(1));
    busy_nxt   = (state_nxt == S_SHIFT);
    done_nxt   = (state_nxt == S_DONE);
  end

  // Per-digit add-3 correction, then one-bit left shift of {scratch, shift_reg}.
  always_comb begin
    scratch_adj = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
    {scratch_shf, shift_shf} = {scratch_adj[BCD_W-2:0], shift_reg, 1'b0};
`ifdef LEADING_ZERO_BLANK_EN
    final_bcd = blank_lead(scratch_shf);
`else
    final_bcd = scratch_shf;
`endif
  end

  // Datapath registers: capture on start, shift during SHIFT, publish on the last shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      scratch   <= '0;
      cnt       <= '0;
      bcd_out   <= RST_BCD;
    end else if (capture) begin
      shift_reg <= bin_in;
      scratch   <= '0;
      cnt       <= CNT_W'(BIN_W);
    end else if (state == S_SHIFT) begin
      shift_reg <= shift_shf;
      scratch   <= scratch_shf;
      cnt       <= cnt - CNT_W'(1);
      if (last_shift) bcd_out <= final_bcd;
    end
  end

  // Registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_nxt;
      done <= done_nxt;
    end
  end

endmodule
